alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one instance of the 32-bit ALU between two requesters: requester 0 is the pipeline EX stage, requester 1 is the cache/address unit.
- Arbitrates between the requesters with round-robin priority.
- Supports short locked sequences, so one requester can issue back-to-back ops without interleaving.
- Masks shift amounts to RISC-V semantics and registers the ALU result into a single-entry response buffer with valid/ready backpressure.

Parameters:
- DATA_W, 32: operand/result width. Fixed at 32 to match the ALU.
- LOCK_MAX, 4: maximum consecutive ops granted to one requester under lock before a forced release. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid&&ready)
- req0_op / req1_op  in  4  ALU op code: 0000 pass b, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 slt
- req0_a / req1_a  in  DATA_W  operand 1
- req0_b / req1_b  in  DATA_W  operand 2
- req0_lock / req1_lock  in  1  keep grant after this op
- rsp_valid  out  1  result buffer full
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that produced rsp_data
- rsp_data  out  DATA_W  registered ALU result

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - rr_ptr=0, state=IDLE, lock_cnt=0.
  - Both reqN_ready are forced 0 while rst_n=0.
  - Reset mid-lock drops the lock. A held response is discarded.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Ready: combinational. reqN_ready = slot_free && rst_n && grant_N. At most one reqN_ready is high in any cycle.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE grant rules:
  - Only one valid requester: grant it.
  - Both valid: grant requester rr_ptr.
- LOCKn: only requester n may be granted. The other requester waits even if n is idle.
- On each accept:
  - From IDLE with lock=1 → LOCKn, lock_cnt=1. rr_ptr unchanged.
  - From IDLE with lock=0 → stay IDLE, rr_ptr = !n.
  - In LOCKn with lock=0 → IDLE, lock_cnt=0, rr_ptr = !n.
  - In LOCKn with lock=1 → lock_cnt+1. If the new count equals LOCK_MAX → forced IDLE, lock_cnt=0, rr_ptr = !n.
- Operand conditioning: for ops 0110/0111/1000, b is zero-extended from b[4:0] before reaching the ALU. All other ops pass b unmodified.
- Undefined ops 1011–1111 are accepted normally and return 0.
- Latency: accept at edge N loads rsp_data=ALU(op,a,b'), rsp_id=n and rsp_valid=1, all visible after edge N. One cycle, no bubbles.
- Response hold: while rsp_valid && !rsp_ready, rsp_data and rsp_id are stable and no new request is accepted.
- Drain:
  - Drain without accept → rsp_valid=0. rsp_data keeps its last value.
  - Drain and accept in the same cycle → the new result replaces the old one and rsp_valid stays 1. Full throughput is one op per cycle.
- Request inputs are sampled only on accept. reqN_valid dropping without acceptance has no side effect.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- With the macro, three 32-bit outputs are added, all reset to 0 and wrapping modulo 2^32:
  - stat_grant0: counts accepts from requester 0.
  - stat_grant1: counts accepts from requester 1.
  - stat_stall: counts cycles where some reqN_valid=1 but no accept occurs.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles with both valid=1 → both ready=0, rsp_valid=0. After release, first grant goes to req0 and rsp_id=0.
- Single op: req0 add a=5, b=7, rsp_ready=1 → accept cycle N. Cycle N+1 shows rsp_valid=1, rsp_data=12, rsp_id=0.
- Round-robin: both valid continuously, rsp_ready=1, req0 sub 10-3, req1 xor 0xF0^0x0F → grant order 0,1,0,1 and rsp_data alternating 7, 0xFF.
- Backpressure: rsp_ready=0 while a result is held → both ready=0 and rsp_data stable for 5 cycles. Raising rsp_ready → drain and next accept in the same cycle, with rsp_valid continuous.
- Lock: LOCK_MAX=4, req0 lock=1 for 6 ops, req1 valid → grants 0,0,0,0,1,0. Also req0 lock released on op 2 → grants 0,0,1.
- Operand/edge cases:
  - sll a=1, b=0x21 → 2.
  - sra a=0x80000000, b=31 → 0xFFFFFFFF.
  - slt 0xFFFFFFFF<1 → 1; sltu → 0.
  - op 1111 → 0.
  - pass b=0x12345000 → 0x12345000.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response bundle between two ALU requesters, the arbiter and the result consumer
interface alu_share_arbiter_if #(parameter int DATA_W = 32);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_lock;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_lock;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_lock,
        output req1_valid, req1_op, req1_a, req1_b, req1_lock,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_lock,
        input  req1_valid, req1_op, req1_a, req1_b, req1_lock,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin/lockable sharing of one 32-bit ALU with a one-entry response buffer
// Optional grant/stall counters enabled by ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]          stat_grant0,
    output logic [31:0]          stat_grant1,
    output logic [31:0]          stat_stall
`endif
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            state;
    logic              rr_ptr;
    logic [3:0]        lock_cnt;

    logic              slot_free;
    logic              grant0, grant1;
    logic              accept0, accept1, accept;
    logic              sel_id, sel_lock;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b, b_cond, alu_res;
    logic [3:0]        new_cnt;

    assign slot_free = !bus.rsp_valid || bus.rsp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            LOCK0: grant0 = bus.req0_valid;
            LOCK1: grant1 = bus.req1_valid;
            default: begin
                grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
                grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
            end
        endcase
    end

    assign bus.req0_ready = slot_free && rst_n && grant0;
    assign bus.req1_ready = slot_free && rst_n && grant1;

    assign accept0 = bus.req0_valid && bus.req0_ready;
    assign accept1 = bus.req1_valid && bus.req1_ready;
    assign accept  = accept0 || accept1;

    assign sel_id   = accept1;
    assign sel_op   = sel_id ? bus.req1_op   : bus.req0_op;
    assign sel_a    = sel_id ? bus.req1_a    : bus.req0_a;
    assign sel_b    = sel_id ? bus.req1_b    : bus.req0_b;
    assign sel_lock = sel_id ? bus.req1_lock : bus.req0_lock;

    // Shift ops see only the low five bits of b, as RISC-V shifts do.
    always_comb begin
        b_cond = sel_b;
        if (sel_op == 4'b0110 || sel_op == 4'b0111 || sel_op == 4'b1000)
            b_cond = {{(DATA_W-5){1'b0}}, sel_b[4:0]};
    end

    always_comb begin
        alu_res = '0;
        case (sel_op)
            4'b0000: alu_res = b_cond;
            4'b0001: alu_res = sel_a + b_cond;
            4'b0010: alu_res = sel_a - b_cond;
            4'b0011: alu_res = sel_a & b_cond;
            4'b0100: alu_res = sel_a | b_cond;
            4'b0101: alu_res = sel_a ^ b_cond;
            4'b0110: alu_res = sel_a << b_cond[4:0];
            4'b0111: alu_res = sel_a >> b_cond[4:0];
            4'b1000: alu_res = $signed(sel_a) >>> b_cond[4:0];
            4'b1001: alu_res = {{(DATA_W-1){1'b0}}, (sel_a < b_cond)};
            4'b1010: alu_res = {{(DATA_W-1){1'b0}}, ($signed(sel_a) < $signed(b_cond))};
            default: alu_res = '0;
        endcase
    end

    // Count of locked ops including this one; a lock entered from IDLE starts at 1.
    assign new_cnt = (state == IDLE) ? 4'd1 : lock_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            lock_cnt      <= 4'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
`ifdef ALU_ARB_STATS_EN
            stat_grant0   <= 32'd0;
            stat_grant1   <= 32'd0;
            stat_stall    <= 32'd0;
`endif
        end else begin
            if (accept) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= sel_id;
                bus.rsp_data  <= alu_res;
                if (sel_lock && new_cnt != 4'(LOCK_MAX)) begin
                    state    <= sel_id ? LOCK1 : LOCK0;
                    lock_cnt <= new_cnt;
                end else begin
                    state    <= IDLE;
                    lock_cnt <= 4'd0;
                    rr_ptr   <= !sel_id;
                end
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
`ifdef ALU_ARB_STATS_EN
            if (accept0)
                stat_grant0 <= stat_grant0 + 32'd1;
            if (accept1)
                stat_grant1 <= stat_grant1 + 32'd1;
            if ((bus.req0_valid || bus.req1_valid) && !accept)
                stat_stall  <= stat_stall + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed-vector bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    alu_share_arbiter_if #(.DATA_W(32)) bus ();

    alu_share_arbiter #(.DATA_W(32), .LOCK_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req0_op = op;
        bus.req0_a  = a;
        bus.req0_b  = b;
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req1_op = op;
        bus.req1_a  = a;
        bus.req1_b  = b;
    endtask

    // Drive valids/locks, check readies mid-cycle, then check the response after the edge.
    task automatic step(input string tag, input logic v0, input logic v1, input logic l0,
                        input logic er0, input logic er1, input logic ev, input logic eid,
                        input logic [31:0] ed);
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_lock  = l0;
        #1;
        check({tag, ".ready0"}, {31'd0, bus.req0_ready}, {31'd0, er0});
        check({tag, ".ready1"}, {31'd0, bus.req1_ready}, {31'd0, er1});
        @(posedge clk);
        #1;
        check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, ev});
        check({tag, ".rsp_id"},    {31'd0, bus.rsp_id},    {31'd0, eid});
        check({tag, ".rsp_data"},  bus.rsp_data, ed);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_lock  = 1'b0;
        bus.req1_lock  = 1'b0;
        bus.rsp_ready  = 1'b1;
        set0(4'b0001, 32'd5, 32'd7);
        set1(4'b0000, 32'd0, 32'h1234_5000);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst.ready0", {31'd0, bus.req0_ready}, 32'd0);
            check("rst.ready1", {31'd0, bus.req1_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            check("rst.rsp_id",    {31'd0, bus.rsp_id},    32'd0);
            check("rst.rsp_data",  bus.rsp_data, 32'd0);
        end
        rst_n = 1'b1;

        step("first_add",  1, 1, 0, 1, 0, 1, 0, 32'd12);
        step("drain_idle", 0, 0, 0, 0, 0, 0, 0, 32'd12);
        step("pass_b",     0, 1, 0, 0, 1, 1, 1, 32'h1234_5000);

        set0(4'b0010, 32'd10, 32'd3);
        set1(4'b0101, 32'hF0, 32'h0F);
        step("rr0", 1, 1, 0, 1, 0, 1, 0, 32'd7);
        step("rr1", 1, 1, 0, 0, 1, 1, 1, 32'hFF);
        step("rr2", 1, 1, 0, 1, 0, 1, 0, 32'd7);
        step("rr3", 1, 1, 0, 0, 1, 1, 1, 32'hFF);

        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step("hold", 1, 1, 0, 0, 0, 1, 1, 32'hFF);
        bus.rsp_ready = 1'b1;
        step("drain_accept", 1, 1, 0, 1, 0, 1, 0, 32'd7);
        step("drain2",       0, 0, 0, 0, 0, 0, 0, 32'd7);

        set1(4'b0110, 32'd1, 32'h21);
        step("sll_mask", 0, 1, 0, 0, 1, 1, 1, 32'd2);

        set0(4'b0001, 32'd1, 32'd1);
        set1(4'b0100, 32'h10, 32'h01);
        step("lock1",     1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("lock2",     1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("lock_wait", 0, 1, 1, 0, 0, 0, 0, 32'd2);
        step("lock3",     1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("lock4",     1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("lock_rel",  1, 1, 1, 0, 1, 1, 1, 32'h11);
        step("lock6",     1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("unlock7",   1, 1, 0, 1, 0, 1, 0, 32'd2);
        step("after7",    1, 1, 0, 0, 1, 1, 1, 32'h11);

        step("early1", 1, 1, 1, 1, 0, 1, 0, 32'd2);
        step("early2", 1, 1, 0, 1, 0, 1, 0, 32'd2);
        step("early3", 1, 1, 0, 0, 1, 1, 1, 32'h11);

        set0(4'b1000, 32'h8000_0000, 32'd31);
        step("sra", 1, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
        set0(4'b1010, 32'hFFFF_FFFF, 32'd1);
        step("slt", 1, 0, 0, 1, 0, 1, 0, 32'd1);
        set0(4'b1001, 32'hFFFF_FFFF, 32'd1);
        step("sltu", 1, 0, 0, 1, 0, 1, 0, 32'd0);
        set0(4'b1111, 32'd5, 32'd7);
        step("undef_op", 1, 0, 0, 1, 0, 1, 0, 32'd0);
        set0(4'b0111, 32'h8000_0000, 32'h24);
        step("srl_mask", 1, 0, 0, 1, 0, 1, 0, 32'h0800_0000);
        set0(4'b0010, 32'd0, 32'd1);
        step("sub_wrap", 1, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
        step("final_drain", 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
